apb_rr_master: RTL

- Multi-requester APB master for the team's APB memory slave.
- Accepts single-transfer requests from NREQ local requesters and arbitrates between them round-robin.
- Sequences the winning request through the APB SETUP/ACCESS phases and returns read data, error status and a one-cycle done pulse to the winner.
- Adds a PREADY timeout so a stalled slave cannot hang the bus.

---
 rtl/apb_rr_master.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/apb_rr_master.sv
// apb_rr_master: round-robin arbiter in front of an APB master sequencer.
// Runs single SETUP/ACCESS transfers, aborts on PREADY timeout and pulses a done to the winner.
`default_nettype none

module apb_rr_master #(
  parameter int NREQ    = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            _PCLK,
  input  logic            _PRESETn,
  input  logic [NREQ-1:0] req_valid,
  input  logic [NREQ-1:0] req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0] rsp_done,
  output logic [DW-1:0]   rsp_rdata,
  output logic            rsp_err,
  output logic            _PSEL1,
  output logic            _PENABLE,
  output logic            _PWRITE,
  output logic [AW-1:0]   _PADDR,
  output logic [DW-1:0]   _PWDATA,
  input  logic [DW-1:0]   _PRDATA,
  input  logic            _PREADY,
  input  logic            _PSLVERR
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_e;

  state_e          state_q;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   win_q;
  logic [CW-1:0]   cnt_q;
  logic            psel_q;
  logic            penable_q;
  logic            pwrite_q;
  logic [AW-1:0]   paddr_q;
  logic [DW-1:0]   pwdata_q;
  logic [NREQ-1:0] done_q;
  logic [DW-1:0]   rdata_q;
  logic            err_q;

  logic            complete;
  logic            abort;
  logic            grant;
  logic [NREQ-1:0] win_oh;
  logic [NREQ-1:0] arb_req;
  logic            arb_any;
  logic [IW-1:0]   arb_idx;
  logic [IW-1:0]   arb_cand;
  logic [IW-1:0]   ptr_d;
  int              arb_sum;

  assign complete = (state_q == S_ACCESS) && _PREADY;
  assign abort    = (state_q == S_ACCESS) && !_PREADY && (cnt_q == CW'(TIMEOUT - 1));
  assign win_oh   = NREQ'(1) << win_q;
  // The completing requester still shows its old valid on the completion edge.
  assign arb_req  = req_valid & ~(complete ? win_oh : '0);
  assign grant    = ((state_q == S_IDLE) || complete) && arb_any;
  assign ptr_d    = (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;

  // Scan downward so the candidate closest to the pointer is assigned last.
  always_comb begin
    arb_any  = 1'b0;
    arb_idx  = '0;
    arb_cand = '0;
    arb_sum  = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      arb_sum = int'(ptr_q) + k;
      if (arb_sum >= NREQ) arb_sum = arb_sum - NREQ;
      arb_cand = IW'(arb_sum);
      if (arb_req[arb_cand]) begin
        arb_any = 1'b1;
        arb_idx = arb_cand;
      end
    end
  end

  always_ff @(posedge _PCLK or negedge _PRESETn) begin
    if (!_PRESETn) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      win_q     <= '0;
      cnt_q     <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      done_q    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      done_q <= '0;
      err_q  <= 1'b0;
      case (state_q)
        S_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (complete) begin
            done_q    <= win_oh;
            err_q     <= _PSLVERR;
            rdata_q   <= pwrite_q ? '0 : _PRDATA;
            state_q   <= S_IDLE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
          end else if (abort) begin
            done_q    <= win_oh;
            err_q     <= 1'b1;
            rdata_q   <= '0;
            state_q   <= S_IDLE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      // A grant overrides the IDLE fall-back above, giving back-to-back SETUP.
      if (grant) begin
        state_q   <= S_SETUP;
        psel_q    <= 1'b1;
        penable_q <= 1'b0;
        win_q     <= arb_idx;
        ptr_q     <= ptr_d;
        cnt_q     <= '0;
        pwrite_q  <= req_write[arb_idx];
        paddr_q   <= req_addr[arb_idx*AW +: AW];
        if (req_write[arb_idx]) pwdata_q <= req_wdata[arb_idx*DW +: DW];
      end
    end
  end

  assign rsp_done  = done_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign _PSEL1    = psel_q;
  assign _PENABLE  = penable_q;
  assign _PWRITE   = pwrite_q;
  assign _PADDR    = paddr_q;
  assign _PWDATA   = pwdata_q;

endmodule

`default_nettype wire
